// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and widths for the instruction-fetch queue
package if_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - PC, instruction-memory and decode handshake bundle
interface if_fetch_queue_if;

    logic [if_pkg::XLEN-1:0] pc_in;
    logic                    pc_stall;
    logic                    imem_req_valid;
    logic                    imem_req_ready;
    logic [if_pkg::XLEN-1:0] imem_req_addr;
    logic                    imem_rsp_valid;
    logic [if_pkg::ILEN-1:0] imem_rsp_data;
    logic                    flush;
    logic                    id_valid;
    logic                    id_ready;
    logic [if_pkg::XLEN-1:0] id_pc;
    logic [if_pkg::ILEN-1:0] id_instr;

    // Fetch queue side: issues memory requests and presents instructions to decode.
    modport master (
        input  pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, id_ready,
        output pc_stall, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
    );

    // Surrounding pipeline and memory side.
    modport slave (
        output pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, id_ready,
        input  pc_stall, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
    );

endinterface

// File: rtl/if_entry_fifo.sv
// rtl/if_entry_fifo.sv - fetch entry storage with allocate, fill and pop pointers
module if_entry_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH) + 1,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [ILEN-1:0] fill_instr_i,
    input  logic            pop_i,
    output fetch_entry_t    head_entry_o,
    output logic            head_valid_o,
    output logic [PW-1:0]   alloc_cnt_o,
    output logic [PW-1:0]   unfilled_cnt_o
);

    fetch_entry_t        entry_q [DEPTH];
    // Pointers carry one extra wrap bit so tail - fill spans 0..DEPTH unambiguously.
    logic [PW-1:0]       head_q;
    logic [PW-1:0]       tail_q;
    logic [PW-1:0]       fill_q;
    logic [PW-1:0]       alloc_cnt_q;

    // Allocate at tail, fill the oldest unfilled entry, pop at head; flush empties everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            alloc_cnt_q <= '0;
        end else begin
            if (alloc_i) begin
                entry_q[tail_q[IW-1:0]] <= '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
                tail_q                  <= tail_q + PW'(1);
            end
            if (fill_i) begin
                entry_q[fill_q[IW-1:0]].instr  <= fill_instr_i;
                entry_q[fill_q[IW-1:0]].filled <= 1'b1;
                fill_q                         <= fill_q + PW'(1);
            end
            if (pop_i) begin
                entry_q[head_q[IW-1:0]].filled <= 1'b0;
                head_q                         <= head_q + PW'(1);
            end
            alloc_cnt_q <= alloc_cnt_q + PW'(alloc_i) - PW'(pop_i);
        end
    end

    assign head_entry_o   = entry_q[head_q[IW-1:0]];
    assign head_valid_o   = head_entry_o.filled && (alloc_cnt_q != '0);
    assign alloc_cnt_o    = alloc_cnt_q;
    assign unfilled_cnt_o = tail_q - fill_q;

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch front end with flush draining and PC stall
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    if_fetch_queue_if.master fq
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q;
    logic [CW-1:0]   drop_cnt_q;
    logic            active_q;
    logic [XLEN-1:0] hold_pc_q;
    logic [ILEN-1:0] hold_instr_q;

    fetch_entry_t    head_entry;
    logic            head_valid;
    logic [CW-1:0]   alloc_cnt;
    logic [CW-1:0]   unfilled_cnt;
    logic [CW-1:0]   remaining;
    logic            run;
    logic            req_valid;
    logic            accept;
    logic            rsp_hit;
    logic            fill;
    logic            pop;
    logic            pc_stall;

    // Request, fill and pop qualification for this cycle.
    always_comb begin
        run       = active_q && (state_q == RUN);
        req_valid = run && (alloc_cnt != CW'(DEPTH)) && !fq.flush;
        accept    = req_valid && fq.imem_req_ready;
        rsp_hit   = run && fq.imem_rsp_valid && (unfilled_cnt != '0);
        fill      = rsp_hit && !fq.flush;
        pop       = head_valid && fq.id_ready;
        remaining = unfilled_cnt - CW'(rsp_hit);
    end

    // Flush wins so the PC can take the redirect target even while draining.
    always_comb begin
        pc_stall = 1'b1;
        if (!active_q) begin
            pc_stall = 1'b1;
        end else if (fq.flush) begin
            pc_stall = 1'b0;
        end else if (state_q == DRAIN) begin
            pc_stall = 1'b1;
        end else begin
            pc_stall = !accept;
        end
    end

    // Keeps outputs in cleared state for the first cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    // Flush with responses still in flight parks in DRAIN until every stale one is swallowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (fq.flush && (remaining != '0)) begin
                        state_q    <= DRAIN;
                        drop_cnt_q <= remaining;
                    end
                end
                DRAIN: begin
                    if (fq.imem_rsp_valid && (drop_cnt_q != '0)) begin
                        drop_cnt_q <= drop_cnt_q - CW'(1);
                        if (drop_cnt_q == CW'(1)) begin
                            state_q <= RUN;
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Remember the last presented instruction so decode sees stable values when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else if (head_valid) begin
            hold_pc_q    <= head_entry.pc;
            hold_instr_q <= head_entry.instr;
        end
    end

    if_entry_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (fq.flush),
        .alloc_i       (accept),
        .alloc_pc_i    (fq.pc_in),
        .fill_i        (fill),
        .fill_instr_i  (fq.imem_rsp_data),
        .pop_i         (pop),
        .head_entry_o  (head_entry),
        .head_valid_o  (head_valid),
        .alloc_cnt_o   (alloc_cnt),
        .unfilled_cnt_o(unfilled_cnt)
    );

    assign fq.imem_req_valid = req_valid;
    assign fq.imem_req_addr  = fq.pc_in;
    assign fq.pc_stall       = pc_stall;
    assign fq.id_valid       = head_valid;
    assign fq.id_pc          = head_valid ? head_entry.pc : hold_pc_q;
    assign fq.id_instr       = head_valid ? head_entry.instr : hold_instr_q;

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction-fetch front end on the consumer side of the program counter. Takes the current PC, issues in-order requests to instruction memory, buffers returning instructions with their PCs in a DEPTH-entry queue, and presents them to decode with a valid/ready handshake. Generates the PC hold signal, so the PC advances only when a fetch request is accepted. Handles pipeline flushes by discarding queued entries and in-flight responses.

## Interface
- XLEN, 64, address/PC width
- ILEN, 32, instruction width
- DEPTH, 4, queue entries, which is also the max of (queued + outstanding); power of 2, ≥2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- pc_in  in  XLEN  current PC from the program counter
- pc_stall  out  1  high: PC must hold; low: PC loads its next value
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address, always equal to pc_in
- imem_rsp_valid  in  1  response valid (no backpressure, in order, ≥1 cycle after accept)
- imem_rsp_data  in  ILEN  fetched instruction
- flush  in  1  redirect/flush pulse from execute
- id_valid  out  1  head entry holds an instruction
- id_ready  in  1  decode consumes head
- id_pc  out  XLEN  PC of head instruction
- id_instr  out  ILEN  head instruction

## Operation
- Queue entries: {pc, instr, filled}. An entry is allocated at request accept with pc = pc_in and filled = 0. The response fills the oldest unfilled entry. Pop occurs on id_valid & id_ready.
- Counters: `alloc_cnt` (entries allocated, 0..DEPTH), `drop_cnt` (responses to discard, 0..DEPTH); width $clog2(DEPTH)+1.
- FSM states:
  - RUN: imem_req_valid = (alloc_cnt < DEPTH) & ~flush.
  - DRAIN: imem_req_valid = 0; every imem_rsp_valid is discarded and decrements drop_cnt.
- Transitions:
  - RUN→DRAIN on flush when in-flight responses remain after this cycle (unfilled entries minus any response this cycle > 0). drop_cnt is loaded with that count.
  - RUN→RUN on flush otherwise.
  - DRAIN→RUN in the cycle drop_cnt goes 1→0.
  - Flush in DRAIN adds nothing, since no requests were issued.
- pc_stall:
  - ~(imem_req_valid & imem_req_ready) in normal operation.
  - Forced 0 in the flush cycle, so the PC loads the redirect target.
  - 1 in DRAIN.
- Flush clears all queue entries, alloc_cnt, and head/tail pointers in the same edge. id_valid is 0 the following cycle.
- Response in the flush cycle belongs to pre-flush traffic and is dropped.
- Simultaneous push (allocate), fill, and pop in one cycle are all legal. alloc_cnt net change = accept − pop.
- Pointers wrap modulo DEPTH.

## Timing
- While reset is asserted, and in the cycle after release, all outputs are driven from cleared state:
  - imem_req_valid=0, pc_stall=1
  - id_valid=0, id_pc=0, id_instr=0
  - FSM=RUN, counters=0
- Reset mid-operation abandons all state. Responses arriving after reset are not the block's concern.
- Request path is combinational from pc_in, imem_req_ready, and flush. Zero-cycle accept to pc_stall low.
- Response latency into the queue: response at edge N; id_valid is high at N+1 if the entry is at the head.
- Full-queue throughput: one instruction per cycle when memory responds with 1-cycle latency and decode is always ready.
- Full (alloc_cnt==DEPTH): imem_req_valid=0, pc_stall=1 until a pop.
- Empty: id_valid=0. id_pc and id_instr hold their last values.

## Structure
- Shared package `if_pkg` holds: XLEN/ILEN defaults, FSM enum {RUN, DRAIN}, and the entry struct type.
- One sub-module, `if_entry_fifo`: entry storage, head/tail/fill pointers, and alloc_cnt. The top level holds the FSM, drop_cnt, handshake, and stall logic.

## Test plan
- **Reset, then steady fetch.** Stimulus: pc_in=0x0, 0x4, 0x8…, ready=1, 1-cycle response, id_ready=1. Required: id_pc sequence 0x0, 0x4, 0x8 with matching instrs; pc_stall=0 every cycle after the first.
- **Backpressure fill.** Stimulus: id_ready=0 for 10 cycles. Required: exactly 4 requests accepted; then imem_req_valid=0 and pc_stall=1. One pop re-enables exactly one request.
- **Memory stall.** Stimulus: imem_req_ready=0 for 3 cycles. Required: pc_stall=1 and imem_req_addr stable for those 3 cycles; no allocation.
- **Flush with 2 outstanding.** Stimulus: latency 3, flush asserted. Required: pc_stall=0 in the flush cycle; DRAIN for 2 responses, both discarded; id_valid=0 throughout; RUN resumes and the first id_pc equals the redirect PC.
- **Flush coincident with response and pop.** Required: that response is dropped, drop_cnt = remaining unfilled count, and no entry is popped twice.
- **Async reset mid-DRAIN.** Required: all outputs return to reset values immediately, independent of clk.
